// File: rtl/poly_seg_pkg.sv
// Shared descriptor layout and state encoding for the polynomial segment sequencer.
package poly_seg_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} seg_state_t;

  function automatic int C_OFS(input int bc, input int i);
    return i * bc;
  endfunction

  function automatic int DT_OFS(input int bc);
    return 6 * bc;
  endfunction

  function automatic int N_OFS(input int bc, input int bt);
    return 6 * bc + bt;
  endfunction

  function automatic int DESC_W(input int bc, input int bt, input int bn);
    return 6 * bc + bt + bn;
  endfunction

endpackage

// File: rtl/seg_fifo.sv
// Synchronous descriptor FIFO with registered full/empty flags and a combinational head.
module seg_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/poly_seg_seq.sv
// Segment sequencer: pops queued descriptors and emits a t = k*dt ramp per segment,
// holding the segment's coefficients, back-to-back with no gap between segments.
module poly_seg_seq
  import poly_seg_pkg::*;
#(
  parameter int BC      = 16,
  parameter int BT      = 16,
  parameter int BN      = 16,
  parameter int FIFO_AW = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [DESC_W(BC,BT,BN)-1:0] s_tdata,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  output logic        [BT-1:0]        t_out,
  output logic signed [BC-1:0]        c0_out,
  output logic signed [BC-1:0]        c1_out,
  output logic signed [BC-1:0]        c2_out,
  output logic signed [BC-1:0]        c3_out,
  output logic signed [BC-1:0]        c4_out,
  output logic signed [BC-1:0]        c5_out,
  output logic                        m_valid,
  output logic                        m_last,
  output logic                        busy
);

  localparam int DW = DESC_W(BC, BT, BN);

  seg_state_t            state;
  seg_state_t            state_nxt;
  logic                  rdy_en;
  logic                  push;
  logic                  pop;
  logic                  load;
  logic                  seg_end;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DW-1:0]         head;
  logic [BN-1:0]         head_n;
  logic [BT-1:0]         head_dt;
  logic signed [BC-1:0]  coef [6];
  logic [BT-1:0]         dt_r;
  logic [BT-1:0]         acc;
  logic [BN-1:0]         n_r;
  logic [BN-1:0]         k;

  // Ready is held low until the first edge after reset release.
  assign s_tready = rdy_en & ~fifo_full;
  assign push     = s_tvalid & s_tready;
  assign head_n   = head[N_OFS(BC, BT) +: BN];
  assign head_dt  = head[DT_OFS(BC) +: BT];
  assign seg_end  = (state == RUN) && (k == n_r - BN'(1));

  seg_fifo #(.W(DW), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .wdata (s_tdata),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    if (state == IDLE || seg_end) begin
      state_nxt = IDLE;
      if (!fifo_empty) begin
        pop = 1'b1;
        if (head_n != '0) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
    end
  end

  // Stage p0: segment state, accumulator and sample counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      rdy_en <= 1'b0;
      dt_r   <= '0;
      n_r    <= '0;
      acc    <= '0;
      k      <= '0;
      for (int i = 0; i < 6; i++) coef[i] <= '0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
      if (load) begin
        for (int i = 0; i < 6; i++) coef[i] <= $signed(head[C_OFS(BC, i) +: BC]);
        dt_r <= head_dt;
        n_r  <= head_n;
        acc  <= '0;
        k    <= '0;
      end else if (state == RUN) begin
        acc <= acc + dt_r;
        k   <= k + BN'(1);
      end
    end
  end

  // Stage p1: registered outputs to the evaluator.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t_out   <= '0;
      c0_out  <= '0;
      c1_out  <= '0;
      c2_out  <= '0;
      c3_out  <= '0;
      c4_out  <= '0;
      c5_out  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      busy <= (state == RUN) | ~fifo_empty;
      if (state == RUN) begin
        t_out   <= acc;
        c0_out  <= coef[0];
        c1_out  <= coef[1];
        c2_out  <= coef[2];
        c3_out  <= coef[3];
        c4_out  <= coef[4];
        c5_out  <= coef[5];
        m_valid <= 1'b1;
        m_last  <= seg_end;
      end else begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_poly_seg_seq.sv
// Directed bench for poly_seg_seq: ramp values, segment chaining, FIFO full, n=0, wrap, reset.
module tb_poly_seg_seq;

  localparam int DW  = 6*16 + 16 + 16;
  localparam int DW8 = 6*16 + 8 + 16;

  logic            clk;
  logic            rstn;
  logic [DW-1:0]   s_tdata;
  logic            s_tvalid;
  logic            s_tready;
  logic [15:0]     t_out;
  logic signed [15:0] c0_out, c1_out, c2_out, c3_out, c4_out, c5_out;
  logic            m_valid;
  logic            m_last;
  logic            busy;

  logic [DW8-1:0]  s8_tdata;
  logic            s8_tvalid;
  logic            s8_tready;
  logic [7:0]      t8_out;
  logic signed [15:0] c80, c81, c82, c83, c84, c85;
  logic            m8_valid;
  logic            m8_last;
  logic            busy8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] log_t [$];
  logic [95:0] log_c [$];
  logic        log_l [$];
  int          log_cy [$];

  poly_seg_seq #(.BC(16), .BT(16), .BN(16), .FIFO_AW(2)) dut (
    .clk(clk), .rstn(rstn), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .t_out(t_out), .c0_out(c0_out), .c1_out(c1_out), .c2_out(c2_out), .c3_out(c3_out),
    .c4_out(c4_out), .c5_out(c5_out), .m_valid(m_valid), .m_last(m_last), .busy(busy)
  );

  poly_seg_seq #(.BC(16), .BT(8), .BN(16), .FIFO_AW(2)) dut8 (
    .clk(clk), .rstn(rstn), .s_tdata(s8_tdata), .s_tvalid(s8_tvalid), .s_tready(s8_tready),
    .t_out(t8_out), .c0_out(c80), .c1_out(c81), .c2_out(c82), .c3_out(c83),
    .c4_out(c84), .c5_out(c85), .m_valid(m8_valid), .m_last(m8_last), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_valid) begin
      log_t.push_back(t_out);
      log_c.push_back({c5_out, c4_out, c3_out, c2_out, c1_out, c0_out});
      log_l.push_back(m_last);
      log_cy.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [15:0] cb, input logic [15:0] dt,
                                       input logic [15:0] n);
    return {n, dt, cb + 16'd5, cb + 16'd4, cb + 16'd3, cb + 16'd2, cb + 16'd1, cb};
  endfunction

  function automatic logic [95:0] cv(input logic [15:0] cb);
    return {cb + 16'd5, cb + 16'd4, cb + 16'd3, cb + 16'd2, cb + 16'd1, cb};
  endfunction

  task automatic push(input logic [DW-1:0] d, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_tready && n < 400) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = -1;
    if (!s_tready) begin
      chk("push_timeout", s_tready, 1);
    end else begin
      s_tdata  = d;
      s_tvalid = 1'b1;
      @(posedge clk);
      #1;
      acc_cyc  = cyc;
      s_tvalid = 1'b0;
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int a, a5, b, b2, L, n;
    logic [7:0] t8 [3];
    logic       l8 [3];

    rstn = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s8_tdata = '0; s8_tvalid = 1'b0;
    #2;
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mlast", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tout", t_out, 0);
    chk("rst_coef", {c5_out, c4_out, c3_out, c2_out, c1_out, c0_out}, 0);
    chk("rst_tready", s_tready, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("rel_tready_pre", s_tready, 0);
    @(posedge clk);
    #1 chk("rel_tready_post", s_tready, 1);

    // single segment
    b = log_t.size();
    push(mk(16'd1, 16'h0010, 16'd4), a);
    wait_neg(7);
    chk("s_count", log_t.size() - b, 4);
    chk("s_lat", log_cy[b] - a, 2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s_t%0d", i), log_t[b+i], 16'h0010 * i);
      chk($sformatf("s_c%0d", i), log_c[b+i], cv(16'd1));
      chk($sformatf("s_last%0d", i), log_l[b+i], i == 3);
    end
    chk("s_end_valid", m_valid, 0);
    chk("s_end_busy", busy, 0);

    // back-to-back A then B
    b = log_t.size();
    push(mk(16'h0100, 16'd5, 16'd3), a);
    push(mk(16'h0200, 16'd7, 16'd2), a);
    wait_neg(10);
    chk("bb_count", log_t.size() - b, 5);
    begin
      logic [15:0] et [5] = '{16'd0, 16'd5, 16'd10, 16'd0, 16'd7};
      logic        el [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("bb_t%0d", i), log_t[b+i], et[i]);
        chk($sformatf("bb_last%0d", i), log_l[b+i], el[i]);
        chk($sformatf("bb_c%0d", i), log_c[b+i], (i < 3) ? cv(16'h0100) : cv(16'h0200));
        chk($sformatf("bb_cyc%0d", i), log_cy[b+i] - log_cy[b], i);
      end
    end

    // FIFO full while a long segment runs
    b = log_t.size();
    push(mk(16'h0300, 16'd1, 16'd100), a);
    wait_neg(4);
    for (int j = 1; j <= 4; j++) push(mk(16'h0010 + 16'(j), 16'(j), 16'd2), a);
    chk("full_tready", s_tready, 0);
    push(mk(16'h0015, 16'd5, 16'd2), a5);
    push(mk(16'h0016, 16'd6, 16'd2), a);
    wait_neg(20);
    chk("full_count", log_t.size() - b, 112);
    if (log_t.size() - b == 112) begin
      L = log_cy[b+99];
      chk("full_d0_last", log_l[b+99], 1);
      chk("full_reopen", a5 - L, 1);
      chk("full_contig", log_cy[b+111] - log_cy[b], 111);
      for (int j = 1; j <= 6; j++) begin
        chk($sformatf("full_seg%0d_c", j), log_c[b+100+2*(j-1)], cv(16'h0010 + 16'(j)));
        chk($sformatf("full_seg%0d_t1", j), log_t[b+101+2*(j-1)], j);
      end
    end

    // n=0 descriptor between two segments
    b = log_t.size();
    push(mk(16'h0400, 16'd3, 16'd2), a);
    push(mk(16'h0500, 16'd1, 16'd0), a);
    push(mk(16'h0600, 16'd4, 16'd2), a);
    wait_neg(10);
    chk("z_count", log_t.size() - b, 4);
    if (log_t.size() - b == 4) begin
      chk("z_gap0", log_cy[b+1] - log_cy[b], 1);
      chk("z_gap1", log_cy[b+2] - log_cy[b+1], 2);
      chk("z_gap2", log_cy[b+3] - log_cy[b+2], 1);
      chk("z_cA", log_c[b+1], cv(16'h0400));
      chk("z_cB", log_c[b+2], cv(16'h0600));
      chk("z_tB", log_t[b+3], 4);
    end

    // BT=8 accumulator wrap
    @(negedge clk);
    s8_tdata  = {16'd3, 8'h80, cv(16'h0020)};
    s8_tvalid = 1'b1;
    @(posedge clk);
    #1 s8_tvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!m8_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("w_seen", m8_valid, 1);
    for (int i = 0; i < 3; i++) begin
      t8[i] = t8_out;
      l8[i] = m8_last;
      @(negedge clk);
    end
    chk("w_t0", t8[0], 8'h00);
    chk("w_t1", t8[1], 8'h80);
    chk("w_t2", t8[2], 8'h00);
    chk("w_last", {l8[0], l8[1], l8[2]}, 3'b001);
    chk("w_end", m8_valid, 0);

    // asynchronous reset mid-segment
    b = log_t.size();
    push(mk(16'h0700, 16'd1, 16'd10), a);
    push(mk(16'h0800, 16'd1, 16'd3), a);
    push(mk(16'h0810, 16'd1, 16'd3), a);
    n = 0;
    while (log_t.size() < b + 3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("r_reached", log_t.size() - b, 3);
    #2 rstn = 1'b0;
    #1;
    chk("r_mvalid", m_valid, 0);
    chk("r_mlast", m_last, 0);
    chk("r_tout", t_out, 0);
    chk("r_coef", {c5_out, c4_out, c3_out, c2_out, c1_out, c0_out}, 0);
    chk("r_busy", busy, 0);
    chk("r_tready", s_tready, 0);
    b2 = log_t.size();
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("r_tready_pre", s_tready, 0);
    @(posedge clk);
    #1 chk("r_tready_post", s_tready, 1);
    wait_neg(20);
    chk("r_quiet", log_t.size() - b2, 0);
    chk("r_busy_after", busy, 0);
    push(mk(16'h0900, 16'd2, 16'd2), a);
    wait_neg(6);
    chk("r_new_count", log_t.size() - b2, 2);
    if (log_t.size() - b2 == 2) begin
      chk("r_new_c", log_c[b2], cv(16'h0900));
      chk("r_new_t1", log_t[b2+1], 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
